// File: rtl/aes_key_sreg_ti.sv
// aes_key_sreg_ti: byte-serial, Boolean-shared AES key-state register.
// Each share holds a KEYBYTES-deep byte chain. All shares shift in
// lockstep, and share data is never combined.
// The handshaked load FSM runs IDLE -> LOAD -> READY.
// In READY the chain steps in rotate mode or in update mode.
// Optional feature macro: KEY_ZEROIZE_EN makes ClearxSI wipe the key state.
module aes_key_sreg_ti #(
    parameter  int SHARES   = 2,
    parameter  int KEYBYTES = 16,
    parameter  int TAPA     = 7,
    parameter  int TAPB     = 6,
    parameter  int W3TAP    = 3,
    localparam int DW       = 8 * SHARES,
    localparam int CW       = $clog2(KEYBYTES + 1)
) (
    input  logic          ClkxCI,
    input  logic          RstxRI,
    input  logic          ClearxSI,
    input  logic          LoadxSI,
    input  logic          InValidxSI,
    output logic          InReadyxSO,
    input  logic [DW-1:0] KeyInxDI,
    input  logic          StepxSI,
    input  logic          RotxSI,
    input  logic [DW-1:0] UpdInxDI,
    input  logic          TapSelxSI,
    output logic [DW-1:0] KeyOutxDO,
    output logic [DW-1:0] KeyToSboxOutxDO,
    output logic [DW-1:0] K03xDO,
    output logic          KeyValidxSO,
    output logic [CW-1:0] CntxDO
);

    // Encoding chosen so that InReadyxSO and KeyValidxSO are plain state bits.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        LOAD  = 2'b01,
        READY = 2'b10
    } state_e;

    state_e                         state_q, state_d;
    logic [CW-1:0]                  cnt_q, cnt_d;
    logic [KEYBYTES-1:0][DW-1:0]    key_q, key_d;
    logic                           shift_en;
    logic [DW-1:0]                  shift_in;

    // Next-state, counter and shift-chain logic.
    // The priority order is clear, then load, then data transfer.
    always_comb begin
        // NOTE: every signal gets a default first, so no path can infer a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        key_d    = key_q;
        shift_en = 1'b0;
        shift_in = KeyInxDI;

        if (ClearxSI) begin
            state_d = IDLE;
            cnt_d   = '0;
`ifdef KEY_ZEROIZE_EN
            key_d   = '0;
`endif
        end else if (LoadxSI) begin
            // Old key bytes stay in the chain until new bytes shift them out.
            state_d = LOAD;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: ;
                LOAD: begin
                    if (InValidxSI) begin
                        shift_en = 1'b1;
                        shift_in = KeyInxDI;
                        cnt_d    = cnt_q + 1'b1;
                        if (cnt_q == CW'(KEYBYTES - 1)) begin
                            state_d = READY;
                        end
                    end
                end
                READY: begin
                    if (StepxSI) begin
                        shift_en = 1'b1;
                        shift_in = RotxSI ? key_q[0] : UpdInxDI;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (shift_en) begin
            for (int i = 0; i < KEYBYTES - 1; i++) begin
                key_d[i] = key_q[i + 1];
            end
            key_d[KEYBYTES - 1] = shift_in;
        end
    end

    // State, counter and key registers with synchronous active-high reset.
    always_ff @(posedge ClkxCI) begin
        if (RstxRI) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            // NOTE: the key chain is reset on purpose so that no partial or stale key survives a reset.
            key_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments let every byte move one place on the same edge.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            key_q   <= key_d;
        end
    end

    assign InReadyxSO      = state_q[0];
    assign KeyValidxSO     = state_q[1];
    assign CntxDO          = cnt_q;
    assign KeyOutxDO       = key_q[0];
    assign K03xDO          = key_q[W3TAP];
    assign KeyToSboxOutxDO = TapSelxSI ? key_q[TAPB] : key_q[TAPA];

endmodule

// File: tb/tb_aes_key_sreg_ti.sv
// tb_aes_key_sreg_ti: self-checking bench for aes_key_sreg_ti with 2 shares and 16 key bytes.
// Stimulus is driven #1 after each rising edge. Expected results are queued
// with the stimulus and compared #1 after the next rising edge.
module tb_aes_key_sreg_ti;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear = 1'b0, load = 1'b0, in_valid = 1'b0, step = 1'b0, rot = 1'b0, tap_sel = 1'b0;
    logic [15:0] key_in = '0, upd_in = '0;
    logic        in_ready, key_valid;
    logic [15:0] key_out, key_sbox, k03;
    logic [4:0]  cnt;

    int n_checks = 0;
    int n_errors = 0;

    aes_key_sreg_ti dut (
        .ClkxCI          (clk),
        .RstxRI          (rst),
        .ClearxSI        (clear),
        .LoadxSI         (load),
        .InValidxSI      (in_valid),
        .InReadyxSO      (in_ready),
        .KeyInxDI        (key_in),
        .StepxSI         (step),
        .RotxSI          (rot),
        .UpdInxDI        (upd_in),
        .TapSelxSI       (tap_sel),
        .KeyOutxDO       (key_out),
        .KeyToSboxOutxDO (key_sbox),
        .K03xDO          (k03),
        .KeyValidxSO     (key_valid),
        .CntxDO          (cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [15:0] kout;
        logic [15:0] sbox;
        logic [15:0] k03;
        logic        valid;
        logic        ready;
        logic [4:0]  cnt;
        logic        chk_data;
    } exp_t;

    typedef struct {
        logic        step;
        logic        rot;
        logic [15:0] upd;
        logic [15:0] kout;
        logic [15:0] sbox;
        logic [15:0] k03;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[33];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic push_exp(input string name, input logic [15:0] kout, input logic [15:0] sbox,
                            input logic [15:0] k3, input logic valid, input logic ready,
                            input logic [4:0] c, input logic chk_data);
        exp_t e;
        e.name = name; e.kout = kout; e.sbox = sbox; e.k03 = k3;
        e.valid = valid; e.ready = ready; e.cnt = c; e.chk_data = chk_data;
        exp_q.push_back(e);
    endtask

    // One clock, then compare the queued expectation against the registered outputs.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check({e.name, ".valid"}, 32'(key_valid), 32'(e.valid));
            check({e.name, ".ready"}, 32'(in_ready), 32'(e.ready));
            check({e.name, ".cnt"}, 32'(cnt), 32'(e.cnt));
            if (e.chk_data) begin
                check({e.name, ".kout"}, 32'(key_out), 32'(e.kout));
                check({e.name, ".sbox"}, 32'(key_sbox), 32'(e.sbox));
                check({e.name, ".k03"}, 32'(k03), 32'(e.k03));
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ref_k[16];
        logic [15:0] first;
        logic [15:0] exp_k0, exp_k3, exp_k7;
        int          n;
        int          cyc;

        // Reset state.
        push_exp("reset", 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 5'd0, 1'b1);
        tick();
        tick();
        rst = 1'b0;

        // Full load: share 0 carries 0x00..0x0F and share 1 carries 0xA5.
        load = 1'b1;
        push_exp("load_entry", 16'h0, 16'h0, 16'h0, 1'b0, 1'b1, 5'd0, 1'b0);
        tick();
        load = 1'b0;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            key_in   = {8'hA5, 8'(i)};
            push_exp("load_byte", 16'h0, 16'h0, 16'h0, (i == 15), (i != 15), 5'(i + 1), 1'b0);
            tick();
        end
        // A back-to-back valid byte after the last one must not be accepted.
        key_in = 16'hFFFF;
        push_exp("b2b", 16'hA500, 16'hA507, 16'hA503, 1'b1, 1'b0, 5'd16, 1'b1);
        tick();
        in_valid = 1'b0;
        tap_sel = 1'b1;
        #1;
        check("tap_b", 32'(key_sbox), 32'h0000_A506);
        tap_sel = 1'b0;
        #1;
        check("tap_a", 32'(key_sbox), 32'h0000_A507);

        // Vector table: 16 rotates, 1 update, 15 rotates, then 1 idle cycle.
        for (int i = 0; i < 16; i++) ref_k[i] = {8'hA5, 8'(i)};
        for (int v = 0; v < 33; v++) begin
            vecs[v].step = (v != 32);
            vecs[v].rot  = (v != 16);
            vecs[v].upd  = (v == 16) ? 16'h5A5A : 16'h1234;
            if (vecs[v].step) begin
                first = ref_k[0];
                for (int i = 0; i < 15; i++) ref_k[i] = ref_k[i + 1];
                ref_k[15] = vecs[v].rot ? first : vecs[v].upd;
            end
            vecs[v].kout = ref_k[0];
            vecs[v].sbox = ref_k[7];
            vecs[v].k03  = ref_k[3];
        end
        for (int v = 0; v < 33; v++) begin
            step   = vecs[v].step;
            rot    = vecs[v].rot;
            upd_in = vecs[v].upd;
            push_exp($sformatf("vec%0d", v), vecs[v].kout, vecs[v].sbox, vecs[v].k03,
                     1'b1, 1'b0, 5'd16, 1'b1);
            tick();
            if (v == 15) check("rot16_restore", 32'(key_out), 32'h0000_A500);
            if (v == 16) check("upd_kout", 32'(key_out), 32'h0000_A501);
        end
        check("upd_k15", 32'(key_out), 32'h0000_5A5A);

        // LoadxSI together with StepxSI in READY enters LOAD without shifting.
        load = 1'b1;
        step = 1'b1;
        rot  = 1'b1;
        push_exp("load_step", 16'h5A5A, ref_k[7], ref_k[3], 1'b0, 1'b1, 5'd0, 1'b1);
        tick();
        load = 1'b0;

        // Stalled load with StepxSI held high, which must have no effect in LOAD.
        n = 0;
        cyc = 0;
        while (n < 16 && cyc < 64) begin
            in_valid = (cyc % 3 != 1);
            key_in   = {8'h3C, 8'(8'h10 + n)};
            if (in_valid) n++;
            push_exp("stall", 16'h0, 16'h0, 16'h0, (n == 16), (n != 16), 5'(n), 1'b0);
            tick();
            cyc++;
        end
        check("stall_budget", 32'(n), 32'd16);
        in_valid = 1'b0;
        step = 1'b0;
        push_exp("stall_done", 16'h3C10, 16'h3C17, 16'h3C13, 1'b1, 1'b0, 5'd16, 1'b1);
        tick();

        // Abort with ClearxSI after 9 bytes.
        load = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < 9; i++) begin
            in_valid = 1'b1;
            key_in   = {8'hC3, 8'(i)};
            push_exp("ab_byte", 16'h0, 16'h0, 16'h0, 1'b0, 1'b1, 5'(i + 1), 1'b0);
            tick();
        end
        in_valid = 1'b0;
        clear = 1'b1;
`ifdef KEY_ZEROIZE_EN
        exp_k0 = 16'h0; exp_k3 = 16'h0; exp_k7 = 16'h0;
`else
        exp_k0 = 16'h3C19; exp_k3 = 16'h3C1C; exp_k7 = 16'hC300;
`endif
        push_exp("clear", exp_k0, exp_k7, exp_k3, 1'b0, 1'b0, 5'd0, 1'b1);
        tick();
        clear = 1'b0;
        // InValidxSI and StepxSI are ignored in IDLE.
        in_valid = 1'b1;
        step     = 1'b1;
        key_in   = 16'hFFFF;
        push_exp("idle_ign", exp_k0, exp_k7, exp_k3, 1'b0, 1'b0, 5'd0, 1'b1);
        tick();
        in_valid = 1'b0;
        step     = 1'b0;

        // Restart a load in LOAD: the counter clears and no byte is taken.
        load = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            key_in   = {8'h77, 8'(i)};
            push_exp("rs_byte", 16'h0, 16'h0, 16'h0, 1'b0, 1'b1, 5'(i + 1), 1'b0);
            tick();
        end
`ifdef KEY_ZEROIZE_EN
        exp_k0 = 16'h0; exp_k3 = 16'h0; exp_k7 = 16'h0;
`else
        exp_k0 = 16'h3C1E; exp_k3 = 16'hC301; exp_k7 = 16'hC305;
`endif
        load   = 1'b1;
        key_in = 16'hEEEE;
        push_exp("restart", exp_k0, exp_k7, exp_k3, 1'b0, 1'b1, 5'd0, 1'b1);
        tick();
        load = 1'b0;
        for (int i = 0; i < 9; i++) begin
            key_in = {8'h99, 8'(i)};
            push_exp("rs2_byte", 16'h0, 16'h0, 16'h0, 1'b0, 1'b1, 5'(i + 1), 1'b0);
            tick();
        end

        // Reset mid-load overrides LoadxSI and InValidxSI and wipes everything.
        rst  = 1'b1;
        load = 1'b1;
        push_exp("rst_mid", 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 5'd0, 1'b1);
        tick();
        rst      = 1'b0;
        load     = 1'b0;
        in_valid = 1'b0;
        push_exp("post_rst", 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 5'd0, 1'b1);
        tick();

        // ClearxSI has priority over LoadxSI.
        clear = 1'b1;
        load  = 1'b1;
        push_exp("clr_prio", 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 5'd0, 1'b1);
        tick();
        clear = 1'b0;
        load  = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
